adc_capture_framer: RTL and testbench

- Parametrised, multi-channel successor to the single-pair ADC capture adapter.
- Takes already-deserialised parallel ADC samples in the aclk domain and captures a triggered frame of exactly N samples.
- Formats each channel into a fixed-width lane and emits the frame as AXI4-Stream. Includes tlast, real tready backpressure through an internal FIFO, overflow/drop accounting and out-of-range status.
- Sits between the IDDR/deserialiser front end and the DMA stream interconnect.

---
 rtl/adc_capture_pkg.sv | 28 ++
 rtl/adc_capture_fifo.sv | 41 ++++
 rtl/adc_capture_framer.sv | 124 ++++++++++++
 tb/tb_adc_capture_framer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture framer: FSM state encoding, drop-counter width
// and the per-channel lane formatter.
package adc_capture_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;

  localparam int unsigned DROP_W     = 16;
  localparam int unsigned MAX_LANE_W = 256;

  // Widen a right-aligned sample of sample_w bits to a lane; callers truncate to their LANE_W.
  function automatic logic [MAX_LANE_W-1:0] fmt_lane(input logic [MAX_LANE_W-1:0] sample,
                                                      input int unsigned sample_w,
                                                      input bit sign_ext);
    logic [MAX_LANE_W-1:0] lane;
    logic                  msb;
    msb  = 1'b0;
    lane = '0;
    for (int i = 0; i < MAX_LANE_W; i++) begin
      if (i == int'(sample_w) - 1) msb = sample[i];
    end
    for (int i = 0; i < MAX_LANE_W; i++) begin
      if (i < int'(sample_w)) lane[i] = sample[i];
      else                    lane[i] = sign_ext & msb;
    end
    return lane;
  endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// First-word-fall-through beat FIFO with wrap-bit pointers; read data is forced to zero when
// empty so the stream bus idles at 0.
module adc_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adc_capture_framer.sv
// Triggered N-sample frame capture from parallel ADC samples into an AXI4-Stream with tlast,
// FIFO backpressure, drop accounting and per-channel out-of-range status.
module adc_capture_framer
  import adc_capture_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SAMPLE_W   = 14,
  parameter int unsigned LANE_W     = 64,
  parameter int unsigned SIGN_EXT   = 0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       s_sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_sample_data,
  input  logic [NUM_CH-1:0]          s_sample_or,
  input  logic [CNT_W-1:0]           sample_count,
  input  logic                       start_trigger,
  output logic                       start_trigger_ack,
  output logic                       busy,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic [NUM_CH-1:0]          or_sticky,
  output logic [NUM_CH*LANE_W-1:0]   m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  localparam int unsigned DATA_W = NUM_CH * LANE_W;

  cap_state_t           state_q;
  logic [CNT_W-1:0]     remaining_q;
  logic                 ack_q;
  logic                 overflow_q;
  logic [DROP_W-1:0]    drop_count_q;
  logic [NUM_CH-1:0]    or_sticky_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic                 beat_last;
  logic                 head_last;
  logic [DATA_W-1:0]    beat_data;
  logic [DATA_W-1:0]    head_data;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign beat_data[k*LANE_W +: LANE_W] =
        LANE_W'(fmt_lane(MAX_LANE_W'(s_sample_data[k*SAMPLE_W +: SAMPLE_W]), SAMPLE_W,
                         SIGN_EXT != 0));
  end

  // Full is sampled before this cycle's pop, so a freeing pop never rescues a sample.
  assign push      = (state_q == CAPTURE) && s_sample_valid && !fifo_full;
  assign drop      = (state_q == CAPTURE) && s_sample_valid && fifo_full;
  assign beat_last = (remaining_q == CNT_W'(1));
  assign pop       = m_axis_tvalid && m_axis_tready;

  adc_capture_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .wdata ({beat_last, beat_data}),
    .pop   (pop),
    .rdata ({head_last, head_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      ack_q        <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      or_sticky_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_trigger) begin
            ack_q        <= 1'b1;
            remaining_q  <= sample_count;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            or_sticky_q  <= '0;
            if (sample_count != '0) state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (push) begin
            remaining_q <= remaining_q - CNT_W'(1);
            or_sticky_q <= or_sticky_q | s_sample_or;
            if (beat_last) state_q <= DRAIN;
          end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != '1) drop_count_q <= drop_count_q + DROP_W'(1);
          end
        end
        DRAIN: begin
          if (pop && head_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_trigger_ack = ack_q;
  assign busy              = (state_q != IDLE);
  assign overflow          = overflow_q;
  assign drop_count        = drop_count_q;
  assign or_sticky         = or_sticky_q;
  assign m_axis_tvalid     = !fifo_empty;
  assign m_axis_tdata      = head_data;
  assign m_axis_tlast      = head_last;

endmodule

// File: tb/tb_adc_capture_framer.sv
// Scoreboard bench: a zero-fill and a sign-extend framer share one stimulus stream; a frame-level
// reference model predicts beats and status, a negedge monitor checks every handshake.
module tb_adc_capture_framer;

  localparam int unsigned NCH   = 2;
  localparam int unsigned SW    = 14;
  localparam int unsigned LW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 32;
  localparam int unsigned DW    = NCH * LW;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic              s_sample_valid = 1'b0;
  logic [NCH*SW-1:0] s_sample_data = '0;
  logic [NCH-1:0]    s_sample_or = '0;
  logic [CW-1:0]     sample_count = '0;
  logic              start_trigger = 1'b0;
  logic              m_axis_tready = 1'b1;

  logic          ack_z, busy_z, ovf_z, tvalid_z, tlast_z;
  logic          ack_s, busy_s, ovf_s, tvalid_s, tlast_s;
  logic [15:0]   drops_z, drops_s;
  logic [NCH-1:0] or_z, or_s;
  logic [DW-1:0] tdata_z, tdata_s;

  always #5 aclk = ~aclk;

  adc_capture_framer #(
    .NUM_CH (NCH), .SAMPLE_W (SW), .LANE_W (LW), .SIGN_EXT (0), .FIFO_DEPTH (DEPTH), .CNT_W (CW)
  ) dut_z (
    .aclk (aclk), .aresetn (aresetn), .s_sample_valid (s_sample_valid),
    .s_sample_data (s_sample_data), .s_sample_or (s_sample_or), .sample_count (sample_count),
    .start_trigger (start_trigger), .start_trigger_ack (ack_z), .busy (busy_z),
    .overflow (ovf_z), .drop_count (drops_z), .or_sticky (or_z), .m_axis_tdata (tdata_z),
    .m_axis_tvalid (tvalid_z), .m_axis_tready (m_axis_tready), .m_axis_tlast (tlast_z)
  );

  adc_capture_framer #(
    .NUM_CH (NCH), .SAMPLE_W (SW), .LANE_W (LW), .SIGN_EXT (1), .FIFO_DEPTH (DEPTH), .CNT_W (CW)
  ) dut_s (
    .aclk (aclk), .aresetn (aresetn), .s_sample_valid (s_sample_valid),
    .s_sample_data (s_sample_data), .s_sample_or (s_sample_or), .sample_count (sample_count),
    .start_trigger (start_trigger), .start_trigger_ack (ack_s), .busy (busy_s),
    .overflow (ovf_s), .drop_count (drops_s), .or_sticky (or_s), .m_axis_tdata (tdata_s),
    .m_axis_tvalid (tvalid_s), .m_axis_tready (m_axis_tready), .m_axis_tlast (tlast_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame rules over a queue standing in for the beat FIFO.
  typedef struct packed {logic [SW-1:0] s1; logic [SW-1:0] s0; logic last;} beat_t;
  beat_t       sb[$];
  bit          mq[$];
  int          m_state = 0;  // 0 idle, 1 capturing, 2 draining
  int unsigned m_rem = 0;
  bit          exp_ack = 0;
  bit          exp_ovf = 0;
  int          exp_drops = 0;
  logic [1:0]  exp_or = '0;
  int          rd_idx[2] = '{0, 0};
  bit          held_v[2] = '{0, 0};
  logic [DW:0] held_d[2];

  function automatic logic [63:0] exp_lane(input logic [SW-1:0] s, input bit sx);
    logic [63:0] v;
    v = 64'(s);
    if (sx && s >= 14'h2000) v = v + 64'hFFFF_FFFF_FFFF_C000;
    return v;
  endfunction

  task automatic model_step();
    bit pop, room, head_last;
    pop       = m_axis_tready && (mq.size() > 0);
    room      = mq.size() < DEPTH;
    head_last = (mq.size() > 0) ? mq[0] : 1'b0;
    exp_ack   = 0;
    if (m_state == 0) begin
      if (start_trigger) begin
        exp_ack   = 1;
        m_rem     = sample_count;
        exp_ovf   = 0;
        exp_drops = 0;
        exp_or    = '0;
        if (sample_count != 0) m_state = 1;
      end
    end else if (m_state == 1) begin
      if (s_sample_valid) begin
        if (room) begin
          sb.push_back('{s1: s_sample_data[2*SW-1:SW], s0: s_sample_data[SW-1:0],
                         last: (m_rem == 1)});
          mq.push_back(m_rem == 1);
          exp_or = exp_or | s_sample_or;
          m_rem--;
          if (m_rem == 0) m_state = 2;
        end else begin
          exp_ovf = 1;
          if (exp_drops < 65535) exp_drops++;
        end
      end
    end else if (pop && head_last) begin
      m_state = 0;
    end
    if (pop) void'(mq.pop_front());
  endtask

  task automatic model_reset();
    m_state = 0; m_rem = 0; exp_ack = 0; exp_ovf = 0; exp_drops = 0; exp_or = '0;
    mq.delete(); sb.delete(); rd_idx[0] = 0; rd_idx[1] = 0;
  endtask

  task automatic check_status();
    chk("ack_z", ack_z, exp_ack);             chk("ack_s", ack_s, exp_ack);
    chk("busy_z", busy_z, m_state != 0);      chk("busy_s", busy_s, m_state != 0);
    chk("overflow_z", ovf_z, exp_ovf);        chk("overflow_s", ovf_s, exp_ovf);
    chk("drop_count_z", drops_z, exp_drops);  chk("drop_count_s", drops_s, exp_drops);
    chk("or_sticky_z", or_z, exp_or);         chk("or_sticky_s", or_s, exp_or);
    chk("tvalid_z", tvalid_z, mq.size() > 0); chk("tvalid_s", tvalid_s, mq.size() > 0);
  endtask

  task automatic tick();
    @(posedge aclk);
    if (aresetn) model_step();
    #1;
    check_status();
  endtask

  task automatic check_out(input int w, input logic tv, input logic [DW-1:0] td, input logic tl);
    beat_t e;
    if (held_v[w]) begin
      chk($sformatf("stall_valid_%0d", w), tv, 1'b1);
      chk($sformatf("stall_hold_%0d", w), {tl, td}, held_d[w]);
    end
    held_v[w] = tv && !m_axis_tready;
    held_d[w] = {tl, td};
    if (tv && m_axis_tready) begin
      if (rd_idx[w] >= sb.size()) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat_%0d actual=beat required=none at %0t", w, $time);
      end else begin
        e = sb[rd_idx[w]];
        rd_idx[w]++;
        chk($sformatf("lane0_%0d", w), td[63:0], exp_lane(e.s0, w == 1));
        chk($sformatf("lane1_%0d", w), td[127:64], exp_lane(e.s1, w == 1));
        chk($sformatf("tlast_%0d", w), tl, e.last);
      end
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      held_v[0] = 0;
      held_v[1] = 0;
    end else begin
      check_out(0, tvalid_z, tdata_z, tlast_z);
      check_out(1, tvalid_s, tdata_s, tlast_s);
    end
  end

  task automatic rand_inputs(input bit rnd_ready);
    s_sample_valid = ($urandom_range(0, 3) != 0);
    s_sample_data  = NCH*SW'($urandom);
    s_sample_or    = NCH'($urandom_range(0, 3) == 0 ? $urandom : 0);
    if (rnd_ready) m_axis_tready = ($urandom_range(0, 4) < 3);
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    int n;
    n = 0;
    while ((m_state != 0 || mq.size() != 0) && n < 300) begin
      if (rnd) rand_inputs(1);
      tick();
      n++;
    end
    chk({tag, "_done"}, (m_state == 0 && mq.size() == 0), 1'b1);
    m_axis_tready = 1'b1;
  endtask

  task automatic trigger(input int unsigned n);
    sample_count  = n;
    start_trigger = 1'b1;
    tick();
    start_trigger = 1'b0;
  endtask

  initial begin
    #1 aresetn = 1'b0;
    #2;
    chk("rst_ack", ack_z, 1'b0);     chk("rst_busy", busy_z, 1'b0);
    chk("rst_tvalid", tvalid_z, 1'b0); chk("rst_tdata", tdata_z, '0);
    chk("rst_tlast", tlast_s, 1'b0); chk("rst_overflow", ovf_s, 1'b0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Ramp: four beats, lane0 = 1..4.
    s_sample_valid = 1'b1;
    s_sample_data  = '0;
    trigger(4);
    for (int i = 1; i <= 6; i++) begin
      s_sample_data = {SW'(i + 100), SW'(i)};
      tick();
    end
    s_sample_valid = 1'b0;
    wait_done("ramp", 0);

    // Zero-length frame: ack only.
    trigger(0);
    repeat (3) tick();

    // Stall: eight cycles of no-ready starting at the trigger, FIFO fills, drops follow.
    m_axis_tready  = 1'b0;
    s_sample_valid = 1'b1;
    trigger(10);
    for (int i = 1; i <= 7; i++) begin
      s_sample_data = {SW'(i), SW'(i + 50)};
      tick();
    end
    m_axis_tready = 1'b1;
    for (int i = 8; i <= 20; i++) begin
      s_sample_data = {SW'(i), SW'(i + 50)};
      tick();
    end
    s_sample_valid = 1'b0;
    wait_done("stall", 0);
    chk("stall_drop_count", drops_z, 16'd4);
    chk("stall_overflow", ovf_s, 1'b1);

    // Sign extension of a negative and a positive sample.
    trigger(2);
    s_sample_valid = 1'b1;
    s_sample_data  = {14'h0001, 14'h2001};
    tick();
    chk("sx_neg_lane", tdata_s[63:0], 64'hFFFF_FFFF_FFFF_E001);
    chk("sx_pos_lane", tdata_s[127:64], 64'h1);
    chk("zf_neg_lane", tdata_z[63:0], 64'h2001);
    s_sample_data = {14'h2001, 14'h0001};
    tick();
    s_sample_valid = 1'b0;
    wait_done("sign", 0);

    // Trigger held high across several frames.
    sample_count  = 3;
    start_trigger = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(0);
      tick();
    end
    start_trigger = 1'b0;
    wait_done("held", 1);

    // Randomised frames with random backpressure and ignored triggers.
    for (int f = 0; f < 8; f++) begin
      rand_inputs(1);
      trigger($urandom_range(1, 12));
      for (int i = 0; i < 300 && m_state == 1; i++) begin
        rand_inputs(1);
        start_trigger = ($urandom_range(0, 7) == 0);
        tick();
      end
      start_trigger = 1'b0;
      wait_done("rand", 1);
    end

    // Reset while draining three queued beats.
    m_axis_tready  = 1'b0;
    s_sample_valid = 1'b1;
    trigger(3);
    repeat (4) tick();
    chk("pre_rst_queued", tvalid_z && busy_z, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_tvalid", tvalid_z, 1'b0); chk("mid_rst_busy", busy_s, 1'b0);
    chk("mid_rst_tdata", tdata_s, '0);     chk("mid_rst_tlast", tlast_z, 1'b0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    m_axis_tready  = 1'b1;
    repeat (6) tick();

    chk("beats_consumed_z", rd_idx[0], sb.size());
    chk("beats_consumed_s", rd_idx[1], sb.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
